pwm_ramp_ctrl: RTL and testbench

Duty-cycle sequencer for the DC-motor PWM path. It accepts speed/direction commands over a valid/ready handshake and ramps the 8-bit compare value fed to the PWM generator's `i_ocr` input toward the target at a programmed rate (soft start/stop). Direction reversals run as ramp-down to zero, a dead-time wait, a direction flip, then ramp-up. It sits between the AXI register bank and the PWM generator/H-bridge direction pin.

---
 rtl/pwm_ctrl_pkg.sv | 39 +++
 rtl/ramp_tick_gen.sv | 22 ++
 rtl/pwm_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared types, widths and defaults for the PWM ramp controller
package pwm_ctrl_pkg;

  localparam int DUTY_W           = 8;
  localparam int DEF_RAMP_DIV     = 100000;
  localparam int DEF_STEP         = 1;
  localparam int DEF_DEAD_CYCLES  = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_DOWN,
    ST_DEAD,
    ST_HOLD
  } state_t;

  // One step from cur toward goal, clamped to goal; 9-bit math so nothing wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] goal,
                                                    input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] g;
    logic [DUTY_W:0] s;
    logic [DUTY_W:0] r;
    c = {1'b0, cur};
    g = {1'b0, goal};
    s = {1'b0, step};
    r = c;
    if (c < g) begin
      r = c + s;
      if (r > g) r = g;
    end else if (c > g) begin
      if ((c - g) <= s) r = g;
      else              r = c - s;
    end
    return r[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - reloadable down-counter producing a tick every load+1 cycles
module ramp_tick_gen #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] load,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || tick)    cnt <= load;
    else                       cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - duty ramp sequencer with reversal dead time; optional o_irq under PWM_RAMP_IRQ_EN
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int RAMP_DIV    = DEF_RAMP_DIV,
  parameter int STEP        = DEF_STEP,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DUTY_W-1:0] i_cmd_duty,
  input  logic              i_cmd_dir,
  input  logic              i_stop,
  output logic [DUTY_W-1:0] o_ocr,
  output logic              o_dir,
  output logic              o_busy
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic              o_irq
`endif
);

  localparam int CNT_MAX = (RAMP_DIV > DEAD_CYCLES) ? RAMP_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

  state_t            state_q, state_n;
  logic [DUTY_W-1:0] ocr_q, ocr_n;
  logic              dir_q, dir_n;
  logic [DUTY_W-1:0] tgt_q, tgt_n;
  logic              tdir_q, tdir_n;
  logic [DUTY_W-1:0] goal;
  logic [CNT_W-1:0]  tick_load;
  logic              tick_clear;
  logic              tick;

  // Counter restarts only on a real state change, so a held stop inside RAMP keeps stepping.
  assign tick_clear = (state_n != state_q);
  assign tick_load  = (state_n == ST_DEAD) ? CNT_W'(DEAD_CYCLES - 1) : CNT_W'(RAMP_DIV - 1);

  ramp_tick_gen #(.W(CNT_W)) u_tick (
    .clk   (i_clk),
    .rst_n (i_reset),
    .clear (tick_clear),
    .load  (tick_load),
    .tick  (tick)
  );

  always_comb begin
    state_n = state_q;
    ocr_n   = ocr_q;
    dir_n   = dir_q;
    tgt_n   = tgt_q;
    tdir_n  = tdir_q;
    goal    = i_stop ? '0 : tgt_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (i_stop) begin
          if (state_q == ST_HOLD) begin
            tgt_n   = '0;
            tdir_n  = dir_q;
            state_n = ST_RAMP;
          end
        end else if (i_cmd_valid) begin
          tgt_n  = i_cmd_duty;
          tdir_n = i_cmd_dir;
          if (i_cmd_dir == dir_q && i_cmd_duty == ocr_q) begin
            state_n = (i_cmd_duty == '0) ? ST_IDLE : ST_HOLD;
          end else if (i_cmd_dir == dir_q || ocr_q == '0) begin
            dir_n   = i_cmd_dir;
            state_n = ST_RAMP;
          end else begin
            state_n = ST_DOWN;
          end
        end
      end
      ST_RAMP: begin
        if (i_stop) begin
          tgt_n  = '0;
          tdir_n = dir_q;
        end
        if (ocr_q == goal) begin
          state_n = (goal == '0) ? ST_IDLE : ST_HOLD;
        end else if (tick) begin
          ocr_n = step_toward(ocr_q, goal, STEP_V);
          if (ocr_n == goal) state_n = (goal == '0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_DOWN: begin
        if (i_stop) begin
          tgt_n   = '0;
          tdir_n  = dir_q;
          state_n = ST_RAMP;
        end else if (tick) begin
          ocr_n = step_toward(ocr_q, '0, STEP_V);
          if (ocr_n == '0) state_n = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (i_stop) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          dir_n   = tdir_q;
          state_n = ST_RAMP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ocr_q   <= '0;
      dir_q   <= 1'b0;
      tgt_q   <= '0;
      tdir_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ocr_q   <= ocr_n;
      dir_q   <= dir_n;
      tgt_q   <= tgt_n;
      tdir_q  <= tdir_n;
    end
  end

  assign o_ocr       = ocr_q;
  assign o_dir       = dir_q;
  assign o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign o_busy      = (state_q == ST_RAMP) || (state_q == ST_DOWN) || (state_q == ST_DEAD);

`ifdef PWM_RAMP_IRQ_EN
  logic irq_q;

  // Completion events: ramp finished (HOLD/IDLE) or a dead-time wait aborted into IDLE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) irq_q <= 1'b0;
    else          irq_q <= ((state_q == ST_RAMP) && (state_n == ST_HOLD || state_n == ST_IDLE)) ||
                           ((state_q == ST_DEAD) && (state_n == ST_IDLE));
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl (RAMP_DIV=4, STEP=16, DEAD_CYCLES=8)
module tb_pwm_ramp_ctrl;

  localparam int RD = 4;
  localparam int ST = 16;
  localparam int DC = 8;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [7:0] i_cmd_duty = '0;
  logic       i_cmd_dir = 1'b0;
  logic       i_stop = 1'b0;
  logic [7:0] o_ocr;
  logic       o_dir;
  logic       o_busy;
`ifdef PWM_RAMP_IRQ_EN
  logic       o_irq;
  int         irq_cnt = 0;
`endif

  pwm_ramp_ctrl #(.RAMP_DIV(RD), .STEP(ST), .DEAD_CYCLES(DC)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_duty  (i_cmd_duty),
    .i_cmd_dir   (i_cmd_dir),
    .i_stop      (i_stop),
    .o_ocr       (o_ocr),
    .o_dir       (o_dir),
    .o_busy      (o_busy)
`ifdef PWM_RAMP_IRQ_EN
    ,
    .o_irq       (o_irq)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int ocr;
    int dir;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  prev_val = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic exp_push(input int ocr, input int dir, input int c);
    ev_t e;
    e.ocr = ocr;
    e.dir = dir;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

`ifdef PWM_RAMP_IRQ_EN
  always @(negedge i_clk) if (o_irq) irq_cnt++;
`endif

  // Every change of {dir, ocr} must match the next expected event, including its cycle.
  always @(negedge i_clk) begin
    int cur;
    ev_t e;
    cur = {23'd0, o_dir, o_ocr};
    if (cur != prev_val) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_change", cur, prev_val);
      end else begin
        e = exp_q.pop_front();
        check_eq("ocr", int'(o_ocr), e.ocr);
        check_eq("dir", int'(o_dir), e.dir);
        if (e.cyc >= 0) check_eq("cycle", cyc, e.cyc);
      end
      prev_val = cur;
    end
  end

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic send_cmd(input int duty, input int dir, output int acc);
    i_cmd_duty  = 8'(duty);
    i_cmd_dir   = dir[0];
    i_cmd_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    acc = cyc;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick_n(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int a;
    int b;
    int n;

    tick_n(3);
    i_reset = 1'b1;
    tick_n(1);
    check_eq("rst_ocr", int'(o_ocr), 0);
    check_eq("rst_dir", int'(o_dir), 0);
    check_eq("rst_ready", int'(o_cmd_ready), 1);
    check_eq("rst_busy", int'(o_busy), 0);

    // Ramp 0 -> 64, dir 0
    send_cmd(64, 0, a);
    for (int k = 1; k <= 4; k++) exp_push(16 * k, 0, a + RD * k);
    check_eq("s1_busy", int'(o_busy), 1);
    check_eq("s1_ready", int'(o_cmd_ready), 0);
    wait_drain(100);
    check_eq("s1_hold_busy", int'(o_busy), 0);
    check_eq("s1_hold_ready", int'(o_cmd_ready), 1);

    // Reversal 64/dir0 -> 32/dir1
    send_cmd(32, 1, a);
    exp_push(48, 0, a + 4);
    exp_push(32, 0, a + 8);
    exp_push(16, 0, a + 12);
    exp_push(0, 0, a + 16);
    exp_push(0, 1, a + 16 + DC);
    exp_push(16, 1, a + 16 + DC + 4);
    exp_push(32, 1, a + 16 + DC + 8);
    while (cyc < a + 20) tick_n(1);
    check_eq("dead_dir", int'(o_dir), 0);
    check_eq("dead_busy", int'(o_busy), 1);
    check_eq("dead_ready", int'(o_cmd_ready), 0);
    wait_drain(200);
    check_eq("s2_hold_busy", int'(o_busy), 0);

    // Same direction ramp down to zero -> IDLE
    send_cmd(0, 1, a);
    exp_push(16, 1, a + 4);
    exp_push(0, 1, a + 8);
    wait_drain(100);
    tick_n(1);
    check_eq("s3_idle_busy", int'(o_busy), 0);

    // Clamp: 40 ends exactly, then 255 ends exactly with no wrap
    send_cmd(40, 1, a);
    exp_push(16, 1, a + 4);
    exp_push(32, 1, a + 8);
    exp_push(40, 1, a + 12);
    wait_drain(100);
    send_cmd(255, 1, a);
    for (int k = 1; k <= 14; k++) exp_push((40 + 16 * k > 255) ? 255 : 40 + 16 * k, 1, a + 4 * k);
    wait_drain(200);
    tick_n(8);
    check_eq("clamp_255", int'(o_ocr), 255);

    // Reverse 255/dir1 -> 0/dir0: down-clamp at 0, dead time, flip, straight to IDLE
    send_cmd(0, 0, a);
    for (int k = 1; k <= 16; k++) exp_push((255 - 16 * k < 0) ? 0 : 255 - 16 * k, 1, a + 4 * k);
    exp_push(0, 0, a + 64 + DC);
    wait_drain(200);
    tick_n(2);
    check_eq("rev0_busy", int'(o_busy), 0);
    check_eq("rev0_ready", int'(o_cmd_ready), 1);

    // Stop at 48 during ramp-up while a command is offered
    send_cmd(96, 0, a);
    exp_push(16, 0, a + 4);
    exp_push(32, 0, a + 8);
    exp_push(48, 0, a + 12);
    n = 0;
    while (o_ocr != 8'd48 && n < 100) begin
      tick_n(1);
      n++;
    end
    check_eq("stop_reach48", int'(o_ocr), 48);
    b = cyc;
    i_stop      = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_duty  = 8'd200;
    i_cmd_dir   = 1'b1;
    exp_push(32, 0, b + 4);
    exp_push(16, 0, b + 8);
    exp_push(0, 0, b + 12);
    wait_drain(100);
    tick_n(2);
    check_eq("stop_busy", int'(o_busy), 0);
    check_eq("stop_ready", int'(o_cmd_ready), 1);
    i_stop      = 1'b0;
    i_cmd_valid = 1'b0;
    tick_n(10);
    check_eq("stop_dir", int'(o_dir), 0);
    check_eq("stop_ocr", int'(o_ocr), 0);

    // Stop during DEAD -> IDLE without a direction flip
    send_cmd(32, 0, a);
    exp_push(16, 0, a + 4);
    exp_push(32, 0, a + 8);
    wait_drain(100);
    send_cmd(16, 1, b);
    exp_push(16, 0, b + 4);
    exp_push(0, 0, b + 8);
    while (cyc < b + 11) tick_n(1);
    check_eq("dead2_busy", int'(o_busy), 1);
    i_stop = 1'b1;
    tick_n(1);
    i_stop = 1'b0;
    check_eq("dead_stop_busy", int'(o_busy), 0);
    tick_n(12);
    check_eq("dead_stop_dir", int'(o_dir), 0);
    check_eq("dead_stop_ready", int'(o_cmd_ready), 1);
    wait_drain(10);

    // Reset mid-ramp drops ocr at once
    send_cmd(128, 0, a);
    exp_push(16, 0, a + 4);
    exp_push(32, 0, a + 8);
    wait_drain(100);
    tick_n(1);
    exp_push(0, 0, -1);
    i_reset = 1'b0;
    #1;
    check_eq("mid_rst_ocr", int'(o_ocr), 0);
    check_eq("mid_rst_busy", int'(o_busy), 0);
    check_eq("mid_rst_ready", int'(o_cmd_ready), 1);
    tick_n(2);
    i_reset = 1'b1;
    wait_drain(10);
    tick_n(4);

`ifdef PWM_RAMP_IRQ_EN
    check_eq("irq_count", irq_cnt, 9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
